// File: rtl/event_trace_player_if.sv
// Loader-side bus of the event trace player: one trace entry offered per cycle
// with a valid/ready handshake.
interface event_trace_player_if #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_W     = 64,
  parameter int DELAY_W    = 16
);
  logic                         wr_valid;
  logic                         wr_ready;
  logic [DELAY_W-1:0]           wr_delay;
  logic [NUM_INPUTS-1:0]        wr_mask;
  logic [NUM_INPUTS*DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_delay, output wr_mask, output wr_data,
                  input  wr_ready);
  modport slave  (input  wr_valid, input  wr_delay, input  wr_mask, input  wr_data,
                  output wr_ready);
endinterface

// File: rtl/event_trace_player.sv
// Replays queued timestamped input events into a monitor: FIFO of
// {delay, mask, data} entries drained by a WAIT/FIRE/GAP sequencer.
module event_trace_player #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_W     = 64,
  parameter int DELAY_W    = 16,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  event_trace_player_if.slave          wr,
  output logic [NUM_INPUTS*DATA_W-1:0] input_data,
  output logic [NUM_INPUTS-1:0]        new_input,
  output logic                         idle,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic [CNT_W-1:0]             events_issued
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = NUM_INPUTS * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE, S_GAP} state_t;

  logic [DELAY_W-1:0]    mem_delay [DEPTH];
  logic [NUM_INPUTS-1:0] mem_mask  [DEPTH];
  logic [LW-1:0]         mem_data  [DEPTH];

  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  state_t                state_reg;
  logic [DELAY_W-1:0]    cnt_reg;
  logic [NUM_INPUTS-1:0] cur_mask_reg;
  logic [LW-1:0]         cur_data_reg;
  logic [NUM_INPUTS-1:0] new_input_reg;
  logic [LW-1:0]         input_data_reg;
  logic [CNT_W-1:0]      events_reg;

  logic                  push, pop, not_empty;
  logic [DELAY_W-1:0]    head_delay;
  logic [NUM_INPUTS-1:0] head_mask;
  logic [LW-1:0]         head_data, head_masked, cur_masked;

  assign wr.wr_ready = (count_reg != CW'(DEPTH));
  assign not_empty   = (count_reg != '0);
  assign push        = wr.wr_valid && wr.wr_ready;
  assign pop         = en && not_empty && (state_reg == S_IDLE || state_reg == S_GAP);

  assign head_delay  = mem_delay[rd_ptr_reg];
  assign head_mask   = mem_mask[rd_ptr_reg];
  assign head_data   = mem_data[rd_ptr_reg];

  // Lanes whose mask bit is clear are driven as zero rather than stale data.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
    assign head_masked[gi*DATA_W +: DATA_W] = head_mask[gi]    ? head_data[gi*DATA_W +: DATA_W]    : '0;
    assign cur_masked[gi*DATA_W +: DATA_W]  = cur_mask_reg[gi] ? cur_data_reg[gi*DATA_W +: DATA_W] : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_delay[wr_ptr_reg] <= wr.wr_delay;
      mem_mask[wr_ptr_reg]  <= wr.wr_mask;
      mem_data[wr_ptr_reg]  <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Strobes are registered on entry to FIRE so they are high exactly while in FIRE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      cur_mask_reg   <= '0;
      cur_data_reg   <= '0;
      new_input_reg  <= '0;
      input_data_reg <= '0;
      events_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_GAP: begin
          new_input_reg  <= '0;
          input_data_reg <= '0;
          state_reg      <= S_IDLE;
          if (pop) begin
            cur_mask_reg <= head_mask;
            cur_data_reg <= head_data;
            cnt_reg      <= head_delay;
            if (head_delay == '0) begin
              state_reg      <= S_FIRE;
              new_input_reg  <= head_mask;
              input_data_reg <= head_masked;
            end else begin
              state_reg <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (en) begin
            cnt_reg <= cnt_reg - DELAY_W'(1);
            if (cnt_reg == DELAY_W'(1)) begin
              state_reg      <= S_FIRE;
              new_input_reg  <= cur_mask_reg;
              input_data_reg <= cur_masked;
            end
          end
        end
        S_FIRE: begin
          new_input_reg  <= '0;
          input_data_reg <= '0;
          state_reg      <= S_GAP;
          if (cur_mask_reg != '0 && events_reg != '1)
            events_reg <= events_reg + CNT_W'(1);
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign new_input     = new_input_reg;
  assign input_data    = input_data_reg;
  assign idle          = (state_reg == S_IDLE) && !not_empty;
  assign fifo_count    = count_reg;
  assign events_issued = events_reg;

endmodule

// File: tb/tb_event_trace_player.sv
// Directed bench for event_trace_player: table of single-event vectors plus
// hand-written sequences for back-to-back, full FIFO, enable stall and reset abort.
module tb_event_trace_player;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [127:0] input_data;
  logic [1:0]   new_input;
  logic         idle;
  logic [3:0]   fifo_count;
  logic [15:0]  events_issued;

  event_trace_player_if #(.NUM_INPUTS(2), .DATA_W(64), .DELAY_W(16)) wr_if ();

  event_trace_player #(
    .NUM_INPUTS(2), .DATA_W(64), .DELAY_W(16), .DEPTH(8), .CNT_W(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .wr            (wr_if),
    .input_data    (input_data),
    .new_input     (new_input),
    .idle          (idle),
    .fifo_count    (fifo_count),
    .events_issued (events_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] delay;
    logic [1:0]  mask;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  exp_ni;
    logic [63:0] exp_d0;
    logic [63:0] exp_d1;
    int          exp_inc;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_evt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] m, input logic [63:0] d0,
                      input logic [63:0] d1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_delay = d;
    wr_if.wr_mask  = m;
    wr_if.wr_data  = {d1, d0};
    step();
    wr_if.wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          stray;
    int          npulse;
    logic [1:0]  ni_s [4];
    logic [63:0] d0_s [4];
    logic [63:0] pv   [$];
    int          pc   [$];

    vecs[0] = '{16'd3, 2'b01, 64'd5,  64'd0,   2'b01, 64'd5,  64'd0, 1};
    vecs[1] = '{16'd0, 2'b10, 64'd11, 64'd9,   2'b10, 64'd0,  64'd9, 1};
    vecs[2] = '{16'd1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7,
                2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1};
    vecs[3] = '{16'd2, 2'b00, 64'd8,  64'd8,   2'b00, 64'd0,  64'd0, 0};
    vecs[4] = '{16'd5, 2'b01, 64'h8000_0000_0000_0000, 64'd123,
                2'b01, 64'h8000_0000_0000_0000, 64'd0, 1};
    vecs[5] = '{16'd0, 2'b11, 64'd1,  64'd2,   2'b11, 64'd1,  64'd2, 1};

    wr_if.wr_valid = 1'b0;
    wr_if.wr_delay = '0;
    wr_if.wr_mask  = '0;
    wr_if.wr_data  = '0;

    // Reset state, then 20 quiet cycles after release with an empty FIFO
    step(); step();
    check("reset_new_input", 128'(new_input), 128'd0);
    check("reset_wr_ready", 128'(wr_if.wr_ready), 128'd1);
    rst = 1'b1;
    en  = 1'b1;
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (idle !== 1'b1 || new_input !== 2'b00 || input_data !== '0 || wr_if.wr_ready !== 1'b1)
        stray++;
    end
    check("post_reset_quiet20", 128'(stray), 128'd0);
    check("post_reset_count", 128'(fifo_count), 128'd0);
    check("post_reset_events", 128'(events_issued), 128'd0);

    // Table of single events pushed while idle: pulse after delay+1 edges
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].delay, vecs[v].mask, vecs[v].d0, vecs[v].d1);
      stray = 0;
      for (int k = 1; k <= int'(vecs[v].delay) + 3; k++) begin
        step();
        if (k == int'(vecs[v].delay) + 1) begin
          check($sformatf("vec%0d_strobe", v), 128'(new_input), 128'(vecs[v].exp_ni));
          check($sformatf("vec%0d_data", v), input_data, {vecs[v].exp_d1, vecs[v].exp_d0});
        end else if (new_input !== 2'b00 || input_data !== '0) begin
          stray++;
        end
      end
      exp_evt += vecs[v].exp_inc;
      check($sformatf("vec%0d_quiet", v), 128'(stray), 128'd0);
      check($sformatf("vec%0d_idle", v), 128'(idle), 128'd1);
      check($sformatf("vec%0d_events", v), 128'(events_issued), 128'(exp_evt));
    end

    // Back-to-back delay-0 entries: pulse, gap, pulse
    en = 1'b0;
    push(16'd0, 2'b01, 64'd3, 64'd0);
    push(16'd0, 2'b01, 64'd4, 64'd0);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      ni_s[k] = new_input;
      d0_s[k] = input_data[63:0];
    end
    check("b2b_pulse0", {62'd0, ni_s[0], d0_s[0]}, {62'd0, 2'b01, 64'd3});
    check("b2b_gap",    {62'd0, ni_s[1], d0_s[1]}, 128'd0);
    check("b2b_pulse1", {62'd0, ni_s[2], d0_s[2]}, {62'd0, 2'b01, 64'd4});
    check("b2b_after",  {62'd0, ni_s[3], d0_s[3]}, 128'd0);
    exp_evt += 2;

    // Fill beyond DEPTH with en low; the 9th entry must be refused
    en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("full_wr_ready%0d", i), 128'(wr_if.wr_ready), (i < 8) ? 128'd1 : 128'd0);
      push(16'd0, 2'b01, 64'(100 + i), 64'd0);
    end
    check("full_count", 128'(fifo_count), 128'd8);
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (new_input !== 2'b00) begin
        pv.push_back(input_data[63:0]);
        pc.push_back(c);
      end
    end
    npulse = pv.size();
    check("full_pulse_count", 128'(npulse), 128'd8);
    for (int i = 0; i < 8 && i < npulse; i++) begin
      check($sformatf("full_order%0d", i), 128'(pv[i]), 128'(100 + i));
      if (i > 0) check($sformatf("full_spacing%0d", i), 128'(pc[i] - pc[i-1]), 128'd2);
    end
    check("full_idle", 128'(idle), 128'd1);
    exp_evt += 8;

    // Enable dropped for 5 edges during WAIT stretches the delay by 5
    push(16'd10, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7);
    stray = 0;
    for (int k = 1; k <= 18; k++) begin
      en = (k >= 4 && k <= 8) ? 1'b0 : 1'b1;
      step();
      if (k == 16) begin
        check("stall_strobe", 128'(new_input), 128'd3);
        check("stall_data", input_data, {64'd7, 64'hFFFF_FFFF_FFFF_FFFF});
      end else if (new_input !== 2'b00 || input_data !== '0) begin
        stray++;
      end
    end
    en = 1'b1;
    exp_evt += 1;
    check("stall_quiet", 128'(stray), 128'd0);
    check("stall_events", 128'(events_issued), 128'(exp_evt));

    // Reset during WAIT with 3 entries still queued
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(16'd20, 2'b01, 64'(50 + i), 64'd0);
    en = 1'b1;
    step(); step(); step();
    check("abort_pre_count", 128'(fifo_count), 128'd3);
    #2;
    rst = 1'b0;
    #1;
    check("abort_outputs", {126'd0, new_input}, 128'd0);
    check("abort_count", 128'(fifo_count), 128'd0);
    check("abort_flags", {126'd0, idle, wr_if.wr_ready}, 128'd3);
    check("abort_events", 128'(events_issued), 128'd0);
    step(); step();
    rst = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (new_input !== 2'b00) stray++;
    end
    check("abort_no_pulse", 128'(stray), 128'd0);
    push(16'd0, 2'b10, 64'd0, 64'd2);
    step();
    check("abort_ch1_pulse", {62'd0, new_input, input_data[127:64]}, {62'd0, 2'b10, 64'd2});
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (new_input !== 2'b00) stray++;
    end
    check("abort_single", 128'(stray), 128'd0);
    check("abort_events_after", 128'(events_issued), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/event_trace_player.md
Name: event_trace_player

Overview:
- Synthesizable, parametrised successor of the monitor stimulus sequence: replays a queued trace of timestamped input events into a topEntity-style monitor with NUM_INPUTS input streams.
- An upstream loader pushes entries of {delay, channel mask, per-channel data} into an internal FIFO.
- The player waits the programmed number of cycles, drives one-cycle new_input_i pulses with data, then forces one idle gap cycle, exactly like the hand-written benches.
- Sits between a trace loader (bench or on-chip ROM/UART) and the monitor's input_i/new_input_i ports.

Parameters:
- NUM_INPUTS, 2, number of monitor input streams.
- DATA_W, 64, width of each signed input value.
- DELAY_W, 16, width of the per-entry delay field in cycles.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the issued-event counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low; clears FIFO, FSM, counter and outputs.
- en  in  1  run enable; gates popping and delay countdown only.
- wr_valid  in  1  loader offers an entry.
- wr_ready  out  1  FIFO not full; an entry is accepted when wr_valid and wr_ready are both high.
- wr_delay  in  DELAY_W  idle cycles before this event's pulse.
- wr_mask  in  NUM_INPUTS  bit i set means channel i fires.
- wr_data  in  NUM_INPUTS*DATA_W  channel i value in bits [i*DATA_W +: DATA_W].
- input_data  out  NUM_INPUTS*DATA_W  registered data to the monitor.
- new_input  out  NUM_INPUTS  registered one-cycle event strobes.
- idle  out  1  high when the FSM is in IDLE and the FIFO is empty.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- events_issued  out  CNT_W  count of FIRE cycles with a non-zero mask; saturates at all-ones.

Behaviour:
- Reset (rst low, asynchronous):
  - new_input=0, input_data=0, FIFO empty (fifo_count=0, wr_ready=1).
  - State=IDLE, idle=1, events_issued=0, delay counter=0.
  - Asserting rst mid-operation aborts the current event and discards queued entries immediately.
- FIFO:
  - Registered circular buffer with no fall-through; a pushed entry can be popped at the earliest on the next cycle.
  - A push while full is not accepted (wr_ready=0); the entry is not stored and no error is raised.
  - Push and pop in the same cycle when not full: both occur and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT, FIRE, GAP.
  - IDLE:
    - If en=1 and the FIFO is not empty, pop the head and load cnt=delay.
    - If delay==0, go to FIRE; otherwise go to WAIT.
  - WAIT:
    - If en=1, decrement cnt; when cnt==1 on a decrementing cycle, go to FIRE.
    - If en=0, hold state and cnt.
  - FIRE (exactly one cycle, independent of en):
    - new_input=mask.
    - input_data lane i = data lane i if mask[i] is set, otherwise 0.
    - Increment events_issued if mask!=0.
    - Always go to GAP.
  - GAP (exactly one cycle, independent of en):
    - new_input=0, input_data=0.
    - If en=1 and the FIFO is not empty, pop and branch as in IDLE; otherwise go to IDLE.
- Timing:
  - An entry popped at cycle t with delay d pulses at cycle t+1+d.
  - Back-to-back delay-0 entries give the pattern pulse, gap, pulse.
  - The minimum event spacing is 2 cycles.
- Outputs are driven from registers, zero outside FIRE.
  - A mask=0 entry still consumes FIRE and GAP cycles with no strobes.
- Multi-channel events: all channels set in the mask pulse in the same cycle (simultaneous RTLola input events).
- events_issued holds at 2^CNT_W-1 once saturated.

Test Plan:
- Reset and release with the FIFO empty -> idle=1, new_input=0, input_data=0, wr_ready=1 for 20 cycles.
- Push {d=3, mask=01, data0=5} while idle with en=1 -> pop on the next cycle, new_input=01 with input_data lane0=5 for exactly one cycle, 4 cycles after the pop, then all zeros; events_issued=1.
- Push {d=0,mask=01,data0=3} then {d=0,mask=01,data0=4} -> pulses at cycles k and k+2 with values 3 and 4, zero at k+1.
- Push 9 entries into DEPTH=8 with en=0 -> wr_ready drops after 8, the 9th is rejected, fifo_count=8.
  - Raise en -> exactly 8 pulses in FIFO order, then idle=1.
- Push {d=10,mask=11,data0=-1,data1=7}; drop en for 5 cycles during WAIT -> pulse delayed by 5 cycles, both strobes high together, lane0 = all-ones and lane1=7.
- Assert rst during WAIT with 3 entries queued -> outputs zero immediately, fifo_count=0, no pulse after release; then push {d=0,mask=10,data1=2} -> a single pulse on channel 1.
